// File: rtl/pipe_hazard_sched.sv
// Pipeline sequencer for the 5-stage MIPS core: load-use stalls, redirect squash,
// memory-wait freeze and a drain-then-halt sequence for BREAK, plus event counters.
module pipe_hazard_sched #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_wait,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_break,
  input  logic             ex_memr,
  input  logic [4:0]       ex_wreg,
  input  logic             ex_redirect,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_flush,
  output logic             back_we,
  output logic             halt,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DC_W-1:0] DC_LOAD = DC_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } st_t;

  st_t             st_q, st_d;
  logic [DC_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic            halt_q;
  logic            lu;
  logic            stall_inc, flush_inc;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Load-use hazard: a load in EX writes a register the ID instruction reads; $0 is exempt.
  always_comb begin
    lu = id_valid & ex_memr & (ex_wreg != 5'd0) &
         ((id_uses_rs & (id_rs == ex_wreg)) | (id_uses_rt & (id_rt == ex_wreg)));
  end

  // Next state and stage enables; everything is held at 0 while reset is asserted.
  always_comb begin
    st_d       = st_q;
    dcnt_d     = dcnt_q;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    pc_we      = 1'b0;
    ifid_we    = 1'b0;
    ifid_flush = 1'b0;
    idex_we    = 1'b0;
    idex_flush = 1'b0;
    back_we    = 1'b0;
    if (!rst) begin
      case (st_q)
        RUN: begin
          if (mem_wait) begin
            // full freeze: nothing moves, nothing counts
          end else if (ex_redirect) begin
            // anything in ID is wrong-path, including a BREAK or a load-use
            pc_we      = 1'b1;
            ifid_we    = 1'b1;
            ifid_flush = 1'b1;
            idex_we    = 1'b1;
            idex_flush = 1'b1;
            back_we    = 1'b1;
            flush_inc  = 1'b1;
          end else if (lu) begin
            idex_we    = 1'b1;
            idex_flush = 1'b1;
            back_we    = 1'b1;
            stall_inc  = 1'b1;
          end else if (id_valid && id_break) begin
            // BREAK never enters EX; front end holds while older work drains
            idex_we    = 1'b1;
            idex_flush = 1'b1;
            back_we    = 1'b1;
            st_d       = DRAIN;
            dcnt_d     = DC_LOAD;
          end else begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
            idex_we = 1'b1;
            back_we = 1'b1;
          end
        end
        DRAIN: begin
          if (!mem_wait) begin
            idex_we    = 1'b1;
            idex_flush = 1'b1;
            back_we    = 1'b1;
            if (dcnt_q == '0) st_d = HALTED;
            else              dcnt_d = dcnt_q - 1'b1;
          end
        end
        HALTED: begin
          // parked until reset
        end
        default: st_d = RUN;
      endcase
    end
  end

  // Control registers: FSM, drain counter, halt flag and saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= RUN;
      dcnt_q  <= '0;
      halt_q  <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      st_q   <= st_d;
      dcnt_q <= dcnt_d;
      halt_q <= (st_d == HALTED);
      if (stall_inc) stall_q <= sat_inc(stall_q);
      if (flush_inc) flush_q <= sat_inc(flush_q);
    end
  end

  assign state     = st_q;
  assign halt      = halt_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule
